// File: rtl/exp4_unidade_controle.sv
// Control unit for the Exp4 memory game: detects each new jogada on the switches,
// sequences the register/compare steps and reports hit, miss or inactivity timeout.
module exp4_unidade_controle #(
    parameter int TIMEOUT = 3000,
    parameter int CW      = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } state_t;

    // With TIMEOUT=0 the counter is pinned at zero and never expires.
    localparam logic [CW-1:0] TLAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            hist_q;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            jogada;
    logic            expirou;

    assign jogada  = (|chaves) & ~hist_q;
    assign expirou = (TIMEOUT != 0) && (tcnt_q == TLAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INICIAL;
            hist_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= |chaves;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        tcnt_d = '0;
        if (state_q == ESPERA) begin
            tcnt_d = (tcnt_q == TLAST) ? tcnt_q : tcnt_q + 1'b1;
        end
    end

    // A jogada arriving in the same cycle the timeout expires takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:     if (iniciar) state_d = PREPARA;
            PREPARA:     state_d = ESPERA;
            ESPERA: begin
                if (jogada)       state_d = REGISTRA;
                else if (expirou) state_d = FIM_TIMEOUT;
            end
            REGISTRA:    state_d = COMPARA;
            COMPARA: begin
                if (!igual)    state_d = FIM_ERRO;
                else if (fimC) state_d = FIM_ACERTO;
                else           state_d = PROXIMO;
            end
            PROXIMO:     state_d = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) state_d = PREPARA;
            default:     state_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            PREPARA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle: walks through a full winning round,
// an error round, timeout expiry and its race with a jogada, and a mid-round reset.
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       igual;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    // Output vector order: zeraC contaC zeraR registraR pronto acertou errou timeout
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_PREP  = 8'b1010_0000;
    localparam logic [7:0] O_REG   = 8'b0001_0000;
    localparam logic [7:0] O_CONTA = 8'b0100_0000;
    localparam logic [7:0] O_ACE   = 8'b0000_1100;
    localparam logic [7:0] O_ERR   = 8'b0000_1010;
    localparam logic [7:0] O_TO    = 8'b0000_1001;

    exp4_unidade_controle #(.TIMEOUT(5), .CW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .chaves    (chaves),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expEstado, input logic [7:0] expOuts);
        logic [11:0] observed;
        logic [11:0] expected;
        observed = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        expected = {expEstado, expOuts};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed estado/outs=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Jogada starting from ESPERA with chaves previously at zero; ends in the result state.
    task automatic doJogada(input string tag, input logic ig, input logic fc, input logic [3:0] expFim);
        chaves = 4'h3;
        igual  = ig;
        fimC   = fc;
        applyStimulus();
        checkOutput({tag, "_registra"}, 4'h4, O_REG);
        chaves = 4'h0;
        applyStimulus();
        checkOutput({tag, "_compara"}, 4'h5, O_NONE);
        applyStimulus();
        case (expFim)
            4'h6:    checkOutput({tag, "_proximo"}, 4'h6, O_CONTA);
            4'hA:    checkOutput({tag, "_acerto"}, 4'hA, O_ACE);
            default: checkOutput({tag, "_erro"}, 4'hE, O_ERR);
        endcase
        if (expFim == 4'h6) begin
            applyStimulus();
            checkOutput({tag, "_espera"}, 4'h2, O_NONE);
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b1;
        chaves  = 4'h0;
        igual   = 1'b0;
        fimC    = 1'b0;

        // 1: reset held two cycles with iniciar asserted
        applyStimulus();
        checkOutput("reset1", 4'h0, O_NONE);
        applyStimulus();
        checkOutput("reset2", 4'h0, O_NONE);
        reset = 1'b0;
        applyStimulus();
        checkOutput("prepara", 4'h1, O_PREP);
        iniciar = 1'b0;
        applyStimulus();
        checkOutput("espera", 4'h2, O_NONE);

        // 2: single correct jogada, then chaves held gives no second pulse
        chaves = 4'h1;
        igual  = 1'b1;
        fimC   = 1'b0;
        applyStimulus();
        checkOutput("j1_registra", 4'h4, O_REG);
        applyStimulus();
        checkOutput("j1_compara", 4'h5, O_NONE);
        applyStimulus();
        checkOutput("j1_proximo", 4'h6, O_CONTA);
        applyStimulus();
        checkOutput("j1_espera", 4'h2, O_NONE);
        applyStimulus();
        checkOutput("held_no_pulse", 4'h2, O_NONE);
        chaves = 4'h0;
        applyStimulus();
        checkOutput("released", 4'h2, O_NONE);

        // 3: remaining 15 jogadas, the last one with fimC set
        for (int i = 2; i <= 15; i++) begin
            doJogada($sformatf("win%0d", i), 1'b1, 1'b0, 4'h6);
        end
        doJogada("win16", 1'b1, 1'b1, 4'hA);
        fimC = 1'b0;
        applyStimulus();
        checkOutput("acerto_hold", 4'hA, O_ACE);
        iniciar = 1'b1;
        applyStimulus();
        checkOutput("acerto_restart", 4'h1, O_PREP);
        iniciar = 1'b0;
        applyStimulus();
        checkOutput("r2_espera", 4'h2, O_NONE);

        // 4: iniciar ignored in ESPERA, then miss at address 2
        iniciar = 1'b1;
        applyStimulus();
        checkOutput("iniciar_ignored", 4'h2, O_NONE);
        iniciar = 1'b0;
        doJogada("e0", 1'b1, 1'b0, 4'h6);
        doJogada("e1", 1'b1, 1'b0, 4'h6);
        doJogada("e2", 1'b0, 1'b0, 4'hE);
        applyStimulus();
        checkOutput("erro_hold1", 4'hE, O_ERR);
        chaves = 4'h5;
        applyStimulus();
        checkOutput("erro_hold2", 4'hE, O_ERR);
        chaves  = 4'h0;
        iniciar = 1'b1;
        applyStimulus();
        checkOutput("erro_restart", 4'h1, O_PREP);
        iniciar = 1'b0;
        applyStimulus();
        checkOutput("r3_espera", 4'h2, O_NONE);

        // 5: no jogada -> timeout exactly 5 cycles after entering ESPERA
        for (int i = 2; i <= 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("to_wait%0d", i), 4'h2, O_NONE);
        end
        applyStimulus();
        checkOutput("timeout", 4'hD, O_TO);
        applyStimulus();
        checkOutput("timeout_hold", 4'hD, O_TO);
        iniciar = 1'b1;
        applyStimulus();
        checkOutput("to_restart", 4'h1, O_PREP);
        iniciar = 1'b0;
        applyStimulus();
        checkOutput("r4_espera", 4'h2, O_NONE);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("race_wait%0d", i), 4'h2, O_NONE);
        end
        chaves = 4'h8;
        igual  = 1'b1;
        applyStimulus();
        checkOutput("race_jogada_wins", 4'h4, O_REG);
        chaves = 4'h0;
        applyStimulus();
        checkOutput("race_compara", 4'h5, O_NONE);

        // 6: reset while in COMPARA
        reset = 1'b1;
        applyStimulus();
        checkOutput("midreset", 4'h0, O_NONE);
        reset = 1'b0;
        applyStimulus();
        checkOutput("idle_after_reset", 4'h0, O_NONE);
        iniciar = 1'b1;
        applyStimulus();
        checkOutput("r5_prepara", 4'h1, O_PREP);
        iniciar = 1'b0;
        applyStimulus();
        checkOutput("r5_espera", 4'h2, O_NONE);
        doJogada("r5", 1'b1, 1'b0, 4'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
